// File: rtl/pc_stack_if.sv
// Command/status bundle between the control unit and pc_stack.
//   master : control unit side (drives commands, data, offset; observes PC/stack status)
//   slave  : pc_stack side
// Signals: stall, jump, branch, call, ret, clr_err, data, offset (commands)
//          addr, depth, ras_empty, ras_full, ovf_err, unf_err (status)
interface pc_stack_if #(
  parameter int unsigned INSADDR_WIDTH = 32,
  parameter int unsigned OFFSET_WIDTH  = 16,
  parameter int unsigned RAS_DEPTH     = 8
);
  localparam int unsigned DEPTH_WIDTH = $clog2(RAS_DEPTH + 1);

  logic                     stall;
  logic                     jump;
  logic                     branch;
  logic                     call;
  logic                     ret;
  logic                     clr_err;
  logic [INSADDR_WIDTH-1:0] data;
  logic [OFFSET_WIDTH-1:0]  offset;
  logic [INSADDR_WIDTH-1:0] addr;
  logic [DEPTH_WIDTH-1:0]   depth;
  logic                     ras_empty;
  logic                     ras_full;
  logic                     ovf_err;
  logic                     unf_err;

  modport master (
    output stall, jump, branch, call, ret, clr_err, data, offset,
    input  addr, depth, ras_empty, ras_full, ovf_err, unf_err
  );

  modport slave (
    input  stall, jump, branch, call, ret, clr_err, data, offset,
    output addr, depth, ras_empty, ras_full, ovf_err, unf_err
  );
endinterface

// File: rtl/pc_stack.sv
// Program counter with hardware return-address stack (RAS).
// Supports sequential step, absolute jump, signed relative branch, call/return,
// stall, and sticky overflow/underflow error flags.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - pc_stack_if.slave: commands in (stall/ret/call/jump/branch/clr_err,
//          data, offset); status out (addr, depth, ras_empty, ras_full,
//          ovf_err, unf_err)
// Command priority: stall > ret > call > jump > branch > sequential.
module pc_stack #(
  parameter int unsigned INSADDR_WIDTH = 32,
  parameter int unsigned OFFSET_WIDTH  = 16,
  parameter int unsigned STEP          = 1,
  parameter int unsigned RAS_DEPTH     = 8
) (
  input logic         clk,
  input logic         rst,
  pc_stack_if.slave   bus
);
  localparam int unsigned AW = INSADDR_WIDTH;
  localparam int unsigned DW = $clog2(RAS_DEPTH + 1);
  localparam int unsigned IW = $clog2(RAS_DEPTH);

  logic [AW-1:0] pc;
  logic [DW-1:0] sp;
  logic [AW-1:0] ras [RAS_DEPTH];
  logic          ovf_q;
  logic          unf_q;

  logic [AW-1:0] pc_step;
  logic [AW-1:0] off_ext;
  logic [AW-1:0] pc_next;
  logic [IW-1:0] push_idx;
  logic [IW-1:0] pop_idx;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          ovf_ev;
  logic          unf_ev;

  assign pc_step  = pc + AW'(STEP);
  assign off_ext  = AW'($signed(bus.offset));
  assign empty    = (sp == '0);
  assign full     = (sp == DW'(RAS_DEPTH));
  // Indices are only used while sp is in range (push: !full, pop: !empty),
  // so truncating sp to the array index width is safe.
  assign push_idx = sp[IW-1:0];
  assign pop_idx  = IW'(sp - DW'(1));

  always_comb begin
    pc_next = pc_step;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_ev  = 1'b0;
    unf_ev  = 1'b0;
    if (bus.stall) begin
      pc_next = pc;
    end else if (bus.ret) begin
      if (empty) begin
        unf_ev = 1'b1;
      end else begin
        pc_next = ras[pop_idx];
        pop     = 1'b1;
      end
    end else if (bus.call) begin
      pc_next = bus.data;
      if (full) ovf_ev = 1'b1;
      else      push   = 1'b1;
    end else if (bus.jump) begin
      pc_next = bus.data;
    end else if (bus.branch) begin
      pc_next = pc + off_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      sp    <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc <= pc_next;
      if (push)     sp <= sp + DW'(1);
      else if (pop) sp <= sp - DW'(1);
      // A new error event overrides a simultaneous clear.
      ovf_q <= (ovf_q & ~bus.clr_err) | ovf_ev;
      unf_q <= (unf_q & ~bus.clr_err) | unf_ev;
    end
  end

  // Stack storage needs no reset; entries above sp are never read.
  always_ff @(posedge clk) begin
    if (push) ras[push_idx] <= pc_step;
  end

  assign bus.addr      = pc;
  assign bus.depth     = sp;
  assign bus.ras_empty = empty;
  assign bus.ras_full  = full;
  assign bus.ovf_err   = ovf_q;
  assign bus.unf_err   = unf_q;
endmodule

// File: tb/tb_pc_stack.sv
module tb_pc_stack;
  logic clk = 1'b0;
  logic rst = 1'b1;

  pc_stack_if #(.INSADDR_WIDTH(32), .OFFSET_WIDTH(16), .RAS_DEPTH(8)) bus ();

  pc_stack #(
    .INSADDR_WIDTH(32),
    .OFFSET_WIDTH (16),
    .STEP         (1),
    .RAS_DEPTH    (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  logic [31:0] exp_ras [8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle_cmds();
    bus.stall   = 1'b0;
    bus.jump    = 1'b0;
    bus.branch  = 1'b0;
    bus.call    = 1'b0;
    bus.ret     = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  // One rising edge, sample 1 time unit later, then drop all commands.
  task automatic tick();
    @(posedge clk);
    #1;
    idle_cmds();
  endtask

  initial begin
    idle_cmds();
    bus.data   = '0;
    bus.offset = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_addr",  bus.addr, 0);
    check("rst_depth", bus.depth, 0);
    check("rst_empty", bus.ras_empty, 1);
    check("rst_full",  bus.ras_full, 0);
    check("rst_ovf",   bus.ovf_err, 0);
    check("rst_unf",   bus.unf_err, 0);

    for (int i = 1; i <= 4; i++) begin
      tick();
      check("seq_addr", bus.addr, i);
    end

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    check("async_rst_addr",  bus.addr, 0);
    check("async_rst_depth", bus.depth, 0);
    rst = 1'b0;
    tick();
    check("post_rst_addr", bus.addr, 1);

    // Branch backward and forward with wrap.
    bus.jump = 1'b1; bus.data = 32'h100; tick();
    check("jump_100", bus.addr, 32'h100);
    bus.branch = 1'b1; bus.offset = 16'hFFF0; tick();
    check("branch_neg", bus.addr, 32'hF0);
    bus.jump = 1'b1; bus.data = 32'hFFFF_FFFF; tick();
    bus.branch = 1'b1; bus.offset = 16'h0002; tick();
    check("branch_wrap", bus.addr, 32'h1);
    bus.jump = 1'b1; bus.data = 32'hFFFF_FFFF; tick();
    tick();
    check("seq_wrap", bus.addr, 32'h0);

    // Nested call / return.
    bus.jump = 1'b1; bus.data = 32'h10; tick();
    bus.call = 1'b1; bus.data = 32'h400; tick();
    check("call1_addr",  bus.addr, 32'h400);
    check("call1_depth", bus.depth, 1);
    tick();
    bus.call = 1'b1; bus.data = 32'h800; tick();
    check("call2_addr",  bus.addr, 32'h800);
    check("call2_depth", bus.depth, 2);
    bus.ret = 1'b1; tick();
    check("ret1_addr",  bus.addr, 32'h402);
    check("ret1_depth", bus.depth, 1);
    bus.ret = 1'b1; tick();
    check("ret2_addr",  bus.addr, 32'h11);
    check("ret2_depth", bus.depth, 0);
    check("ret2_empty", bus.ras_empty, 1);

    // Fill the stack, overflow, then unwind.
    bus.jump = 1'b1; bus.data = 32'h1000; tick();
    exp_ras[0] = 32'h1001;
    for (int i = 1; i < 8; i++) exp_ras[i] = 32'h2000 + (i - 1) * 32'h100 + 1;
    for (int i = 0; i < 8; i++) begin
      bus.call = 1'b1; bus.data = 32'h2000 + i * 32'h100; tick();
    end
    check("fill_full",  bus.ras_full, 1);
    check("fill_depth", bus.depth, 8);
    check("fill_ovf",   bus.ovf_err, 0);
    bus.call = 1'b1; bus.data = 32'h900; tick();
    check("ovf_addr",  bus.addr, 32'h900);
    check("ovf_depth", bus.depth, 8);
    check("ovf_flag",  bus.ovf_err, 1);
    for (int k = 7; k >= 0; k--) begin
      bus.ret = 1'b1; tick();
      check("unwind_addr",  bus.addr, exp_ras[k]);
      check("unwind_depth", bus.depth, k);
    end
    check("ovf_sticky", bus.ovf_err, 1);
    bus.clr_err = 1'b1; tick();
    check("ovf_clr", bus.ovf_err, 0);

    // Underflow and clear-vs-set precedence.
    bus.jump = 1'b1; bus.data = 32'h20; tick();
    bus.ret = 1'b1; tick();
    check("unf_addr",  bus.addr, 32'h21);
    check("unf_flag",  bus.unf_err, 1);
    check("unf_depth", bus.depth, 0);
    bus.ret = 1'b1; bus.clr_err = 1'b1; tick();
    check("unf_set_wins", bus.unf_err, 1);
    check("unf2_addr",    bus.addr, 32'h22);
    bus.clr_err = 1'b1; tick();
    check("unf_clr",   bus.unf_err, 0);
    check("clr_addr",  bus.addr, 32'h23);

    // Stall and priority.
    bus.call = 1'b1; bus.data = 32'h500; tick();
    check("pcall_addr", bus.addr, 32'h500);
    bus.stall = 1'b1; bus.call = 1'b1; bus.jump = 1'b1; bus.data = 32'h700; tick();
    check("stall_addr",  bus.addr, 32'h500);
    check("stall_depth", bus.depth, 1);
    bus.ret = 1'b1; bus.call = 1'b1; bus.jump = 1'b1; bus.data = 32'h900; tick();
    check("prio_ret_addr",  bus.addr, 32'h24);
    check("prio_ret_depth", bus.depth, 0);
    check("prio_ret_ovf",   bus.ovf_err, 0);
    bus.jump = 1'b1; bus.branch = 1'b1; bus.data = 32'h3000; bus.offset = 16'h4; tick();
    check("prio_jump", bus.addr, 32'h3000);

    // Asynchronous reset mid-stack.
    bus.call = 1'b1; bus.data = 32'h4000; tick();
    check("mid_depth", bus.depth, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_addr",  bus.addr, 0);
    check("mid_rst_depth", bus.depth, 0);
    check("mid_rst_empty", bus.ras_empty, 1);
    rst = 1'b0;
    tick();
    check("mid_post_addr", bus.addr, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised program counter for the instruction-fetch path.
- Supports sequential step, absolute jump, signed relative branch, and call/return through an internal hardware return-address stack (RAS).
- Adds stall and sticky overflow/underflow error flags.
- Sits between the control unit, which issues the commands, and instruction memory, which it drives with `addr`.

Parameters:
- INSADDR_WIDTH, 32, width of the program counter and of every address.
- OFFSET_WIDTH, 16, width of the signed branch offset (two's complement); must be <= INSADDR_WIDTH.
- STEP, 1, increment applied per sequential advance, added modulo 2^INSADDR_WIDTH.
- RAS_DEPTH, 8, number of return-address entries; must be >= 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold PC and stack unchanged this cycle.
- jump  input  1  load `data` into PC.
- branch  input  1  PC <= PC + sign_extend(offset).
- call  input  1  push PC+STEP onto RAS; PC <= data.
- ret  input  1  pop RAS top into PC.
- clr_err  input  1  clear sticky error flags.
- data  input  INSADDR_WIDTH  absolute target for jump/call.
- offset  input  OFFSET_WIDTH  signed branch displacement.
- addr  output  INSADDR_WIDTH  current PC, registered.
- depth  output  $clog2(RAS_DEPTH+1)  number of valid RAS entries.
- ras_empty  output  1  depth == 0.
- ras_full  output  1  depth == RAS_DEPTH.
- ovf_err  output  1  sticky: a call was issued while the stack was full.
- unf_err  output  1  sticky: a ret was issued while the stack was empty.

Behaviour:
- Reset, asynchronous: `addr` = 0, `depth` = 0, `ras_empty` = 1, `ras_full` = 0, `ovf_err` = 0, `unf_err` = 0. RAS contents are don't-care.
- All updates occur on the rising clk edge. `addr` reflects the new PC the cycle after the command (1-cycle latency). `depth`, `ras_empty` and `ras_full` are combinational from the registered stack pointer.
- Command priority per cycle, highest first: stall > ret > call > jump > branch > sequential.
  - Lower-priority commands asserted in the same cycle are ignored, with no side effects.
- stall=1: PC, stack and depth hold. Error flags still respond to `clr_err`. Commands asserted with stall are discarded, not queued.
- ret, depth > 0: PC <= RAS[top]; depth decrements.
- ret, depth == 0: PC <= PC + STEP; `unf_err` <= 1; depth stays 0.
- call, depth < RAS_DEPTH: RAS[depth] <= PC + STEP; depth increments; PC <= data.
- call, depth == RAS_DEPTH: PC <= data; push discarded; existing entries unchanged; `ovf_err` <= 1.
- jump: PC <= data.
- branch: offset is sign-extended to INSADDR_WIDTH; PC <= PC + ext(offset), modulo 2^INSADDR_WIDTH.
- No command: PC <= PC + STEP, modulo 2^INSADDR_WIDTH. Wrap-around from all-ones is legal and silent.
- Error flags are sticky until `clr_err` or `rst`.
  - If `clr_err` and a new error event occur in the same cycle, the set wins and the flag is 1 next cycle.
- The pushed return address PC + STEP also wraps modulo 2^INSADDR_WIDTH.
- Reset asserted mid-sequence, at any point including mid-stack: all state returns to reset values asynchronously. After release, the first rising edge applies normal behaviour starting from PC = 0.

Test Plan:
- Reset then 4 idle cycles, W=32, STEP=1 -> addr 0,1,2,3,4. Assert rst asynchronously between edges -> addr = 0 immediately, depth = 0.
- Branch at PC=0x100 with offset=16'hFFF0 (-16) -> addr = 0xF0. Branch at PC=0xFFFFFFFF with offset=+2 -> addr = 0x1 (wrap).
- call data=0x400 at PC=0x10; call data=0x800 at PC=0x401 -> depth = 2. ret -> addr = 0x402, depth = 1. ret -> addr = 0x11, depth = 0, ras_empty = 1.
- Fill stack with 8 calls (RAS_DEPTH=8) -> ras_full = 1. 9th call data=0x900 -> addr = 0x900, depth = 8, ovf_err = 1. 8 rets return the addresses pushed in LIFO order; top entry is unchanged by the dropped push.
- ret at depth 0 from PC=0x20 -> addr = 0x21, unf_err = 1. `clr_err` together with another empty ret -> unf_err stays 1. Lone `clr_err` -> unf_err = 0.
- stall with call and jump asserted -> addr and depth unchanged. Same cycle ret+call+jump at depth 1 -> only the ret executes (pop). Next cycle jump+branch -> addr = data.
